// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data-cache controller.
// Holds the tag/valid array, sequences 4-word line refills and write-through stores.
module dcache_ctrl #(
   parameter int ADDR_W   = 10,
   parameter int INDEX_W  = 5,
   parameter int OFFSET_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] WordAddress,
   output logic              stall,
   output logic              hit,
   output logic              cache_we,
   output logic [ADDR_W-1:0] cache_addr,
   output logic              cache_src,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   output logic [15:0]       hit_cnt,
   output logic [15:0]       miss_cnt
);
   localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
   localparam int LINES = 1 << INDEX_W;

   typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [OFFSET_W-1:0] cnt_q, cnt_d;
   logic [LINES-1:0]    valid_q;
   logic [TAG_W-1:0]    tag_q [LINES];
   logic [15:0]         hit_cnt_q, miss_cnt_q;
   logic                hit_inc, miss_inc, line_fill;
   logic [INDEX_W-1:0]  req_idx, fill_idx;
   logic [TAG_W-1:0]    req_tag, fill_tag;
   logic                lookup;
   logic [ADDR_W-1:0]   refill_addr;

   assign req_idx     = WordAddress[OFFSET_W +: INDEX_W];
   assign req_tag     = WordAddress[ADDR_W-1 -: TAG_W];
   assign fill_idx    = addr_q[OFFSET_W +: INDEX_W];
   assign fill_tag    = addr_q[ADDR_W-1 -: TAG_W];
   assign lookup      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign refill_addr = {addr_q[ADDR_W-1:OFFSET_W], cnt_q};

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      hit_inc    = 1'b0;
      miss_inc   = 1'b0;
      line_fill  = 1'b0;
      stall      = 1'b0;
      hit        = 1'b0;
      cache_we   = 1'b0;
      cache_addr = '0;
      cache_src  = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = '0;
      case (state_q)
         IDLE: begin
            if (MemWrite) begin
               stall   = 1'b1;
               hit     = lookup;
               addr_d  = WordAddress;
               state_d = WRITE;
               if (lookup) begin
                  cache_we   = 1'b1;
                  cache_addr = WordAddress;
                  hit_inc    = 1'b1;
               end else begin
                  miss_inc = 1'b1;
               end
            end else if (MemRead) begin
               hit = lookup;
               if (lookup) begin
                  hit_inc = 1'b1;
               end else begin
                  stall    = 1'b1;
                  addr_d   = {WordAddress[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                  cnt_d    = '0;
                  miss_inc = 1'b1;
                  state_d  = REFILL;
               end
            end
         end
         REFILL: begin
            stall    = 1'b1;
            mem_rd   = 1'b1;
            mem_addr = refill_addr;
            if (mem_ready) begin
               cache_we   = 1'b1;
               cache_src  = 1'b1;
               cache_addr = refill_addr;
               cnt_d      = cnt_q + OFFSET_W'(1);
               if (cnt_q == '1) begin
                  line_fill = 1'b1;
                  state_d   = IDLE;
               end
            end
         end
         WRITE: begin
            mem_wr   = 1'b1;
            mem_addr = addr_q;
            stall    = ~mem_ready;
            if (mem_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A request can still be held while reset is low; keep every output quiet.
      if (!rst) begin
         stall      = 1'b0;
         hit        = 1'b0;
         cache_we   = 1'b0;
         cache_addr = '0;
         cache_src  = 1'b0;
         mem_rd     = 1'b0;
         mem_wr     = 1'b0;
         mem_addr   = '0;
         hit_inc    = 1'b0;
         miss_inc   = 1'b0;
         line_fill  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         cnt_q      <= '0;
         valid_q    <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         if (line_fill) valid_q[fill_idx] <= 1'b1;
         if (hit_inc && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 16'd1;
         if (miss_inc && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (line_fill) tag_q[fill_idx] <= fill_tag;
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed vector table, hand-written reset/conflict sequences,
// then random CPU/memory traffic against a transaction-level cache model.
module tb_dcache_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       MemRead = 1'b0, MemWrite = 1'b0, mem_ready = 1'b0;
   logic [9:0] WordAddress = '0;
   logic       stall, hit, cache_we, cache_src, mem_rd, mem_wr;
   logic [9:0] cache_addr, mem_addr;
   logic [15:0] hit_cnt, miss_cnt;

   dcache_ctrl #(.ADDR_W(10), .INDEX_W(5), .OFFSET_W(2)) dut (
      .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
      .WordAddress(WordAddress), .stall(stall), .hit(hit), .cache_we(cache_we),
      .cache_addr(cache_addr), .cache_src(cache_src), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // cache model: line contents, plus the outstanding memory transaction
   bit mv[32];
   int mt[32];
   int mmode;            // 0 no transaction, 1 line fetch, 2 store-through
   int mblk, mbeat, mwa;
   int mhc, mmc;

   int e_stall, e_hit, e_chkhit, e_we, e_src, e_caddr, e_mrd, e_mwr, e_maddr;
   int s_stall, s_hit, s_we, s_src, s_caddr, s_mrd, s_mwr, s_maddr, s_hc, s_mc;
   int q_beats[$];

   function automatic void chk(string nm, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic void m_reset();
      foreach (mv[i]) mv[i] = 1'b0;
      mmode = 0; mblk = 0; mbeat = 0; mwa = 0; mhc = 0; mmc = 0;
   endfunction

   function automatic bit m_lookup(int a);
      int idx = (a >> 2) & 31;
      return mv[idx] && (mt[idx] == (a >> 7));
   endfunction

   function automatic void m_expect(bit rd, bit wr, int a, bit rdy);
      bit lk = m_lookup(a);
      e_stall = 0; e_hit = 0; e_chkhit = 0; e_we = 0; e_src = 0; e_caddr = 0;
      e_mrd = 0; e_mwr = 0; e_maddr = 0;
      if (mmode == 0) begin
         if (wr) begin
            e_stall = 1; e_hit = lk; e_chkhit = 1;
            if (lk) begin e_we = 1; e_caddr = a; end
         end else if (rd) begin
            e_hit = lk; e_chkhit = 1; e_stall = lk ? 0 : 1;
         end
      end else if (mmode == 1) begin
         e_stall = 1; e_mrd = 1; e_maddr = mblk + mbeat;
         if (rdy) begin e_we = 1; e_src = 1; e_caddr = e_maddr; end
      end else begin
         e_mwr = 1; e_maddr = mwa; e_stall = rdy ? 0 : 1;
      end
   endfunction

   function automatic void m_update(bit rd, bit wr, int a, bit rdy);
      bit lk = m_lookup(a);
      if (mmode == 0) begin
         if (wr || (rd && lk)) begin
            if (lk) begin if (mhc < 65535) mhc++; end
            else if (mmc < 65535) mmc++;
            if (wr) begin mmode = 2; mwa = a; end
         end else if (rd) begin
            if (mmc < 65535) mmc++;
            mmode = 1; mblk = a - (a % 4); mbeat = 0;
         end
      end else if (mmode == 1) begin
         if (rdy) begin
            mbeat++;
            if (mbeat == 4) begin
               mv[(mblk >> 2) & 31] = 1'b1;
               mt[(mblk >> 2) & 31] = mblk >> 7;
               mmode = 0;
            end
         end
      end else if (rdy) begin
         mmode = 0;
      end
   endfunction

   // Entered just after a rising edge; drives one cycle, checks at the falling edge.
   task automatic cycle(bit rd, bit wr, int a, bit rdy);
      MemRead = rd; MemWrite = wr; WordAddress = 10'(a); mem_ready = rdy;
      @(negedge clk);
      m_expect(rd, wr, a, rdy);
      s_stall = int'(stall); s_hit = int'(hit); s_we = int'(cache_we); s_src = int'(cache_src);
      s_caddr = int'(cache_addr); s_mrd = int'(mem_rd); s_mwr = int'(mem_wr);
      s_maddr = int'(mem_addr); s_hc = int'(hit_cnt); s_mc = int'(miss_cnt);
      chk("stall", s_stall, e_stall);
      if (e_chkhit != 0) chk("hit", s_hit, e_hit);
      chk("cache_we", s_we, e_we);
      if (e_we != 0) begin
         chk("cache_src", s_src, e_src);
         chk("cache_addr", s_caddr, e_caddr);
      end
      chk("mem_rd", s_mrd, e_mrd);
      chk("mem_wr", s_mwr, e_mwr);
      if ((e_mrd | e_mwr) != 0) chk("mem_addr", s_maddr, e_maddr);
      chk("hit_cnt", s_hc, mhc);
      chk("miss_cnt", s_mc, mmc);
      if (s_mrd != 0 && rdy) q_beats.push_back(s_maddr);
      @(posedge clk);
      m_update(rd, wr, a, rdy);
      #1;
   endtask

   task automatic do_req(bit rd, bit wr, int a);
      int n = 0;
      do begin
         cycle(rd, wr, a, 1'($urandom_range(0, 1)));
         n++;
      end while (e_stall != 0 && n < 60);
      if (e_stall != 0) begin
         n_cmp++; n_err++;
         $display("FAIL req_timeout: addr %0h still stalled after %0d cycles, required release", a, n);
      end
   endtask

   task automatic chk_all_zero(string tag);
      chk({tag, "_stall"}, int'(stall), 0);
      chk({tag, "_hit"}, int'(hit), 0);
      chk({tag, "_cache_we"}, int'(cache_we), 0);
      chk({tag, "_cache_src"}, int'(cache_src), 0);
      chk({tag, "_cache_addr"}, int'(cache_addr), 0);
      chk({tag, "_mem_rd"}, int'(mem_rd), 0);
      chk({tag, "_mem_wr"}, int'(mem_wr), 0);
      chk({tag, "_mem_addr"}, int'(mem_addr), 0);
      chk({tag, "_hit_cnt"}, int'(hit_cnt), 0);
      chk({tag, "_miss_cnt"}, int'(miss_cnt), 0);
   endtask

   typedef struct {
      bit rd, wr; int a; bit rdy;
      bit stall, hit, chkhit, we, src; int caddr;
      bit mrd, mwr; int maddr;
      int hc, mc;
   } vec_t;

   vec_t tbl[16];

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      //          rd wr addr  rdy  stl hit chk we src caddr  mrd mwr maddr  hc mc
      tbl[0]  = '{0, 1, 'h001, 0,  1,  0,  1,  0, 0, 'h000, 0,  0,  'h000, 0, 0};
      tbl[1]  = '{0, 1, 'h001, 0,  1,  0,  0,  0, 0, 'h000, 0,  1,  'h001, 0, 1};
      tbl[2]  = '{0, 1, 'h001, 0,  1,  0,  0,  0, 0, 'h000, 0,  1,  'h001, 0, 1};
      tbl[3]  = '{0, 1, 'h001, 1,  0,  0,  0,  0, 0, 'h000, 0,  1,  'h001, 0, 1};
      tbl[4]  = '{1, 0, 'h001, 0,  1,  0,  1,  0, 0, 'h000, 0,  0,  'h000, 0, 1};
      tbl[5]  = '{1, 0, 'h001, 1,  1,  0,  0,  1, 1, 'h000, 1,  0,  'h000, 0, 2};
      tbl[6]  = '{1, 0, 'h001, 1,  1,  0,  0,  1, 1, 'h001, 1,  0,  'h001, 0, 2};
      tbl[7]  = '{1, 0, 'h001, 0,  1,  0,  0,  0, 0, 'h000, 1,  0,  'h002, 0, 2};
      tbl[8]  = '{1, 0, 'h001, 1,  1,  0,  0,  1, 1, 'h002, 1,  0,  'h002, 0, 2};
      tbl[9]  = '{1, 0, 'h001, 1,  1,  0,  0,  1, 1, 'h003, 1,  0,  'h003, 0, 2};
      tbl[10] = '{1, 0, 'h001, 0,  0,  1,  1,  0, 0, 'h000, 0,  0,  'h000, 0, 2};
      tbl[11] = '{1, 0, 'h000, 0,  0,  1,  1,  0, 0, 'h000, 0,  0,  'h000, 1, 2};
      tbl[12] = '{0, 1, 'h001, 0,  1,  1,  1,  1, 0, 'h001, 0,  0,  'h000, 2, 2};
      tbl[13] = '{0, 1, 'h001, 1,  0,  0,  0,  0, 0, 'h000, 0,  1,  'h001, 3, 2};
      tbl[14] = '{1, 0, 'h001, 0,  0,  1,  1,  0, 0, 'h000, 0,  0,  'h000, 3, 2};
      tbl[15] = '{0, 0, 'h000, 0,  0,  0,  0,  0, 0, 'h000, 0,  0,  'h000, 4, 2};

      m_reset();
      e_stall = 0;
      // reset with a read held: everything stays low
      MemRead = 1'b1; WordAddress = 10'h001;
      repeat (2) @(posedge clk);
      #2;
      chk_all_zero("por");
      MemRead = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;

      foreach (tbl[i]) begin
         cycle(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].rdy);
         chk($sformatf("t%0d_stall", i), s_stall, int'(tbl[i].stall));
         if (tbl[i].chkhit) chk($sformatf("t%0d_hit", i), s_hit, int'(tbl[i].hit));
         chk($sformatf("t%0d_we", i), s_we, int'(tbl[i].we));
         if (tbl[i].we) begin
            chk($sformatf("t%0d_src", i), s_src, int'(tbl[i].src));
            chk($sformatf("t%0d_caddr", i), s_caddr, tbl[i].caddr);
         end
         chk($sformatf("t%0d_mrd", i), s_mrd, int'(tbl[i].mrd));
         chk($sformatf("t%0d_mwr", i), s_mwr, int'(tbl[i].mwr));
         if (tbl[i].mrd || tbl[i].mwr) chk($sformatf("t%0d_maddr", i), s_maddr, tbl[i].maddr);
         chk($sformatf("t%0d_hit_cnt", i), s_hc, tbl[i].hc);
         chk($sformatf("t%0d_miss_cnt", i), s_mc, tbl[i].mc);
      end

      // conflict on index 0: tag 1 evicts tag 0
      do_req(1'b1, 1'b0, 'h001);
      q_beats.delete();
      do_req(1'b1, 1'b0, 'h081);
      chk("conflict_beats", q_beats.size(), 4);
      foreach (q_beats[i]) chk($sformatf("conflict_beat%0d", i), q_beats[i], 'h080 + i);
      cycle(1'b1, 1'b0, 'h001, 1'b0);
      chk("conflict_reread_miss", s_stall, 1);
      do_req(1'b1, 1'b0, 'h001);

      // reset during the third refill beat
      cycle(1'b1, 1'b0, 'h105, 1'b0);
      cycle(1'b1, 1'b0, 'h105, 1'b1);
      cycle(1'b1, 1'b0, 'h105, 1'b1);
      MemRead = 1'b1; mem_ready = 1'b1;
      #2;
      chk("refill_beat2_mem_rd", int'(mem_rd), 1);
      rst = 1'b0;
      #1;
      chk_all_zero("rst_refill");
      @(posedge clk); #1;
      m_reset();
      rst = 1'b1;
      cycle(1'b1, 1'b0, 'h105, 1'b0);
      chk("rst_reread_miss", s_stall, 1);
      do_req(1'b1, 1'b0, 'h105);

      // reset during a store-through: no retry afterwards
      cycle(1'b0, 1'b1, 'h0A0, 1'b0);
      MemWrite = 1'b1; mem_ready = 1'b0;
      #2;
      chk("write_mem_wr", int'(mem_wr), 1);
      rst = 1'b0;
      #1;
      chk("rst_write_mem_wr", int'(mem_wr), 0);
      @(posedge clk); #1;
      m_reset();
      rst = 1'b1;
      cycle(1'b0, 1'b0, 'h0A0, 1'b1);
      cycle(1'b0, 1'b0, 'h0A0, 1'b0);

      // random traffic; CPU holds its request while stalled
      begin
         bit rd = 0, wr = 0, rdy;
         int a = 0;
         int kind;
         for (int n = 0; n < 500; n++) begin
            if (e_stall == 0) begin
               kind = $urandom_range(0, 7);
               rd = (kind == 1 || kind == 2 || kind == 3 || kind == 7);
               wr = (kind == 4 || kind == 5 || kind == 7);
               a  = ($urandom_range(0, 7) << 7) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            end
            rdy = ($urandom_range(0, 2) != 0);
            cycle(rd, wr, a, rdy);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
